// File: rtl/io_mmio_responder_if.sv
// CPU data-bus port bundle for the I/O responder: one request per cycle, registered responses.
// Latency: not applicable (signal bundle only).
// Backpressure: none; the bus carries no ready signal.
interface io_mmio_responder_if;
  logic [31:0] io_addr;
  logic        io_read;
  logic        io_write;
  logic [15:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        io_wack;
  logic        io_err;

  // CPU side drives requests and observes responses
  modport master (
    output io_addr, io_read, io_write, io_wdata,
    input  io_rdata, io_rvalid, io_wack, io_err
  );

  // Responder side observes requests and drives responses
  modport slave (
    input  io_addr, io_read, io_write, io_wdata,
    output io_rdata, io_rvalid, io_wack, io_err
  );
endinterface

// File: rtl/io_mmio_responder.sv
// MMIO responder owning the LED output register and the synchronized, debounced switch input.
// Latency: responses one cycle after the request; a settled switch change reaches sw_stable after DEBOUNCE_CYCLES+3 edges.
// Backpressure: none; a request is accepted on every cycle.
module io_mmio_responder #(
  parameter int unsigned SW_WIDTH        = 24,
  parameter int unsigned LED_WIDTH       = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] LED_BASE        = 32'hFFFF_FC60,
  parameter logic [31:0] SW_BASE         = 32'hFFFF_FC70
) (
  input  logic                 clk,
  input  logic                 rst,
  io_mmio_responder_if.slave   bus,
  input  logic [SW_WIDTH-1:0]  switch_in,
  output logic [LED_WIDTH-1:0] led_out
);

  localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [SW_WIDTH-1:0] sw_cand;
  logic [SW_WIDTH-1:0] sw_stable;
  logic [CNT_W-1:0]    cnt;

  logic        hit_led_lo;
  logic        hit_led_hi;
  logic        hit_sw_lo;
  logic        hit_sw_hi;
  logic        hit_led;
  logic        rd_req;
  logic        wr_req;
  logic        both_req;
  logic        rd_hit;
  logic [31:0] rd_data;

  // Exact-address decode; any other address, including odd bytes, is unmapped
  assign hit_led_lo = (bus.io_addr == LED_BASE);
  assign hit_led_hi = (bus.io_addr == (LED_BASE + 32'd2));
  assign hit_sw_lo  = (bus.io_addr == SW_BASE);
  assign hit_sw_hi  = (bus.io_addr == (SW_BASE + 32'd2));
  assign hit_led    = hit_led_lo | hit_led_hi;

  assign rd_req   = bus.io_read & ~bus.io_write;
  assign wr_req   = bus.io_write & ~bus.io_read;
  assign both_req = bus.io_read & bus.io_write;

  // Two-flop synchronizer, then a candidate/counter debouncer that saturates once stable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_cand   <= '0;
      sw_stable <= '0;
      cnt       <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
      if (sw_sync != sw_cand) begin
        sw_cand <= sw_sync;
        cnt     <= '0;
      end else if (cnt == CNT_MAX) begin
        sw_stable <= sw_cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Read mux: halfword views of the stable switches and the LED register, zero-extended
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    if (hit_sw_lo) begin
      rd_data = {16'b0, sw_stable[15:0]};
    end else if (hit_sw_hi) begin
      rd_data = {24'b0, sw_stable[23:16]};
    end else if (hit_led_lo) begin
      rd_data = {16'b0, led_out[15:0]};
    end else if (hit_led_hi) begin
      rd_data = {24'b0, led_out[23:16]};
    end else begin
      rd_hit = 1'b0;
    end
  end

  // LED register: only a clean write to an LED halfword changes it; upper write byte ignored for the high half
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_out <= '0;
    end else begin
      if (wr_req && hit_led_lo) begin
        led_out[15:0] <= bus.io_wdata;
      end
      if (wr_req && hit_led_hi) begin
        led_out[23:16] <= bus.io_wdata[7:0];
      end
    end
  end

  // Response pulses and read data; rdata holds between read responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.io_rdata  <= '0;
      bus.io_rvalid <= 1'b0;
      bus.io_wack   <= 1'b0;
      bus.io_err    <= 1'b0;
    end else begin
      bus.io_rvalid <= rd_req;
      bus.io_wack   <= bus.io_write;
      bus.io_err    <= both_req | (rd_req & ~rd_hit) | (wr_req & ~hit_led);
      if (rd_req) begin
        bus.io_rdata <= rd_data;
      end
    end
  end

endmodule
